// File: rtl/fir_coeff_bank_ctrl.sv
// Ping-pong coefficient bank controller for the 321-tap L=3 polyphase FIR.
// Optional checksum of the active bank is built when FIR_COEFF_CHECKSUM_EN is defined.
module fir_coeff_bank_ctrl #(
    parameter int TAP_NUM   = 321,
    parameter int COEFF_W   = 16,
    parameter int IDX_W     = 7,
    parameter int FLUSH_SMP = 325
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [COEFF_W-1:0] cfg_data,
    input  logic               cfg_last,
    input  logic               samp_strobe,
    output logic               wr_en,
    output logic               wr_bank,
    output logic [1:0]         wr_branch,
    output logic [IDX_W-1:0]   wr_index,
    output logic [COEFF_W-1:0] wr_data,
    output logic               active_bank,
    output logic               out_valid,
    output logic               swap_done,
    output logic               load_err,
    output logic               busy,
    output logic [15:0]        coeff_sum
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_PEND  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [1:0]       LAST_BR  = 2'((TAP_NUM - 1) % 3);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((TAP_NUM - 1) / 3);
    localparam int               CNT_W    = $clog2(FLUSH_SMP + 2);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_SMP);

    logic [1:0]         state_q, state_d;
    logic [1:0]         branch_q, branch_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;
    logic               valid_q, valid_d;
    logic               swap_q, swap_d;
    logic               err_q, err_d;
    logic               wr_en_q, wr_en_d;
    logic [1:0]         wr_branch_q, wr_branch_d;
    logic [IDX_W-1:0]   wr_index_q, wr_index_d;
    logic [COEFF_W-1:0] wr_data_q, wr_data_d;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0]        sum_q, sum_d;
    logic [15:0]        csum_q, csum_d;
`endif

    logic accept, is_last;

    // Ready is forced low while reset is held so no beat is lost during reset.
    assign cfg_ready = ~reset & ~state_q[1];
    assign accept    = cfg_valid & cfg_ready;
    assign is_last   = (branch_q == LAST_BR) && (index_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        branch_d    = branch_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        valid_d     = valid_q;
        swap_d      = 1'b0;
        err_d       = 1'b0;
        wr_en_d     = accept;
        wr_branch_d = wr_branch_q;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
`ifdef FIR_COEFF_CHECKSUM_EN
        sum_d       = sum_q;
        csum_d      = csum_q;
`endif
        if (accept) begin
            wr_branch_d = branch_q;
            wr_index_d  = index_q;
            wr_data_d   = cfg_data;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_d = ((state_q == S_IDLE) ? 16'd0 : sum_q) + 16'(cfg_data);
`endif
            if (is_last && cfg_last) begin
                state_d  = S_PEND;
                branch_d = 2'd0;
                index_d  = '0;
            end else if (is_last || cfg_last) begin
                // Malformed load: the beat is still written but the shadow bank is abandoned.
                err_d    = 1'b1;
                state_d  = S_IDLE;
                branch_d = 2'd0;
                index_d  = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                sum_d    = 16'd0;
`endif
            end else begin
                state_d = S_LOAD;
                if (branch_q == 2'd2) begin
                    branch_d = 2'd0;
                    index_d  = index_q + IDX_W'(1);
                end else begin
                    branch_d = branch_q + 2'd1;
                end
            end
        end

        case (state_q)
            S_PEND: if (samp_strobe) begin
                active_d = ~active_q;
                swap_d   = 1'b1;
`ifdef FIR_COEFF_CHECKSUM_EN
                csum_d   = sum_q;
`endif
                if (FLUSH_SMP == 0) begin
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (samp_strobe) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            branch_q    <= 2'd0;
            index_q     <= '0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            valid_q     <= 1'b0;
            swap_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_branch_q <= 2'd0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q       <= 16'd0;
            csum_q      <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            branch_q    <= branch_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            valid_q     <= valid_d;
            swap_q      <= swap_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_branch_q <= wr_branch_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_q      <= csum_d;
`endif
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_bank     = ~active_q;
    assign wr_branch   = wr_branch_q;
    assign wr_index    = wr_index_q;
    assign wr_data     = wr_data_q;
    assign active_bank = active_q;
    assign out_valid   = valid_q;
    assign swap_done   = swap_q;
    assign load_err    = err_q;
    assign busy        = (state_q != S_IDLE);
`ifdef FIR_COEFF_CHECKSUM_EN
    assign coeff_sum   = csum_q;
`else
    assign coeff_sum   = 16'd0;
`endif

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Directed self-checking bench for fir_coeff_bank_ctrl (honours FIR_COEFF_CHECKSUM_EN).
module tb_fir_coeff_bank_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_data = 16'd0;
    logic        cfg_last = 1'b0;
    logic        samp_strobe = 1'b0;
    logic        wr_en, wr_bank, active_bank, out_valid, swap_done, load_err, busy;
    logic [1:0]  wr_branch;
    logic [6:0]  wr_index;
    logic [15:0] wr_data, coeff_sum;

    int tests = 0;
    int fails = 0;

`ifdef FIR_COEFF_CHECKSUM_EN
    localparam logic [15:0] SUM_TAPS  = 16'hC8A0;
    localparam logic [15:0] SUM_CONST = 16'h4100;
`else
    localparam logic [15:0] SUM_TAPS  = 16'h0000;
    localparam logic [15:0] SUM_CONST = 16'h0000;
`endif

    fir_coeff_bank_ctrl dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .samp_strobe(samp_strobe),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_branch(wr_branch), .wr_index(wr_index),
        .wr_data(wr_data), .active_bank(active_bank), .out_valid(out_valid),
        .swap_done(swap_done), .load_err(load_err), .busy(busy), .coeff_sum(coeff_sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends taps start..320; each write is checked one cycle after its beat.
    task automatic do_load(input int start, input bit cnst, input bit last_on_end,
                           input bit strobe_mid, input bit strobe_last,
                           input logic exp_bank, input logic exp_ov, output int bad);
        bad = 0;
        for (int i = start; i <= 320; i++) begin
            cfg_valid   = 1'b1;
            cfg_data    = cnst ? 16'h0100 : 16'(i);
            cfg_last    = last_on_end && (i == 320);
            samp_strobe = (strobe_mid && (i % 50 == 25)) || (strobe_last && (i == 320));
            tick();
            if (wr_en !== 1'b1 || wr_branch !== 2'(i % 3) || wr_index !== 7'(i / 3) ||
                wr_data !== cfg_data || wr_bank !== exp_bank || active_bank !== ~exp_bank ||
                out_valid !== exp_ov || swap_done !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL write tap %0d: en=%b br=%0d idx=%0d data=%h bank=%b act=%b ov=%b, need br=%0d idx=%0d bank=%b ov=%b",
                             i, wr_en, wr_branch, wr_index, wr_data, wr_bank, active_bank,
                             out_valid, i % 3, i / 3, exp_bank, exp_ov);
                bad++;
            end
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; samp_strobe = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            samp_strobe = 1'b1;
            tick();
            samp_strobe = 1'b0;
            tick();
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_last = 1'b0; samp_strobe = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got %b need 0", cfg_ready);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (cfg_ready !== 1'b1 || wr_en !== 1'b0 || wr_bank !== 1'b1 || wr_branch !== 2'd0 ||
            wr_index !== 7'd0 || wr_data !== 16'd0 || active_bank !== 1'b0 || out_valid !== 1'b0 ||
            swap_done !== 1'b0 || load_err !== 1'b0 || busy !== 1'b0 || coeff_sum !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: rdy=%b en=%b bank=%b br=%0d idx=%0d d=%h act=%b ov=%b sw=%b err=%b busy=%b sum=%h need 1,0,1,0,0,0,0,0,0,0,0,0",
                     cfg_ready, wr_en, wr_bank, wr_branch, wr_index, wr_data, active_bank,
                     out_valid, swap_done, load_err, busy, coeff_sum);
        end
    endtask

    task automatic test_full_load();
        int bad;
        do_load(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bad);
        tests++;
        if (bad != 0) begin fails++; $display("FAIL full_load_writes: %0d bad beats need 0", bad); end
        tests++;
        if (wr_branch !== 2'd2 || wr_index !== 7'd106 || wr_data !== 16'd320) begin
            fails++; $display("FAIL last_tap_addr: br=%0d idx=%0d need 2,106", wr_branch, wr_index);
        end
        tests++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || load_err !== 1'b0 || active_bank !== 1'b0) begin
            fails++; $display("FAIL pend_swap: busy=%b rdy=%b err=%b act=%b need 1,0,0,0", busy, cfg_ready, load_err, active_bank);
        end
        tick();
        tests++;
        if (wr_en !== 1'b0) begin fails++; $display("FAIL write_stops: wr_en=%b need 0", wr_en); end
        samp_strobe = 1'b1; tick(); samp_strobe = 1'b0;
        tests++;
        if (active_bank !== 1'b1 || swap_done !== 1'b1 || out_valid !== 1'b0 || coeff_sum !== SUM_TAPS) begin
            fails++; $display("FAIL swap: act=%b sw=%b ov=%b sum=%h need 1,1,0,%h", active_bank, swap_done, out_valid, coeff_sum, SUM_TAPS);
        end
        tick();
        tests++;
        if (swap_done !== 1'b0 || wr_bank !== 1'b0) begin
            fails++; $display("FAIL swap_pulse_end: sw=%b wr_bank=%b need 0,0", swap_done, wr_bank);
        end
        strobes(324);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL flush_324: ov=%b busy=%b need 0,1", out_valid, busy);
        end
        strobes(1);
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_325: ov=%b busy=%b need 1,0", out_valid, busy);
        end
    endtask

    task automatic test_err_early();
        int bad = 0;
        for (int i = 0; i <= 100; i++) begin
            cfg_valid = 1'b1; cfg_data = 16'(i); cfg_last = (i == 100);
            tick();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        tests++;
        if (load_err !== 1'b1 || busy !== 1'b0 || active_bank !== 1'b1 || out_valid !== 1'b1 ||
            wr_en !== 1'b1 || wr_branch !== 2'd1 || wr_index !== 7'd33) begin
            fails++;
            $display("FAIL early_last_err: err=%b busy=%b act=%b ov=%b en=%b br=%0d idx=%0d need 1,0,1,1,1,1,33",
                     load_err, busy, active_bank, out_valid, wr_en, wr_branch, wr_index);
        end
        tick();
        tests++;
        if (load_err !== 1'b0) begin fails++; $display("FAIL err_pulse_end: err=%b need 0", load_err); end
        do_load(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, bad);
        strobes(1);
        tests++;
        if (bad != 0 || active_bank !== 1'b0 || load_err !== 1'b0) begin
            fails++; $display("FAIL reload_after_err: bad=%0d act=%b err=%b need 0,0,0", bad, active_bank, load_err);
        end
        strobes(325);
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL reload_flush: ov=%b busy=%b need 1,0", out_valid, busy);
        end
    endtask

    task automatic test_err_nolast();
        int bad;
        do_load(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, bad);
        tests++;
        if (bad != 0 || load_err !== 1'b1 || busy !== 1'b0 || active_bank !== 1'b0) begin
            fails++; $display("FAIL missing_last_err: bad=%0d err=%b busy=%b act=%b need 0,1,0,0", bad, load_err, busy, active_bank);
        end
        cfg_valid = 1'b1; cfg_data = 16'h00AA; tick(); cfg_valid = 1'b0;
        tests++;
        if (wr_en !== 1'b1 || wr_branch !== 2'd0 || wr_index !== 7'd0 || busy !== 1'b1 || load_err !== 1'b0) begin
            fails++; $display("FAIL restart_tap0: en=%b br=%0d idx=%0d busy=%b err=%b need 1,0,0,1,0", wr_en, wr_branch, wr_index, busy, load_err);
        end
        do_load(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, bad);
        strobes(1);
        tests++;
        if (bad != 0 || active_bank !== 1'b1) begin
            fails++; $display("FAIL restart_complete: bad=%0d act=%b need 0,1", bad, active_bank);
        end
        strobes(325);
    endtask

    task automatic test_coincident_strobe();
        int bad;
        do_load(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, bad);
        tests++;
        if (bad != 0) begin fails++; $display("FAIL strobes_in_load: %0d bad beats need 0", bad); end
        tests++;
        if (active_bank !== 1'b1 || swap_done !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL coincident_ignored: act=%b sw=%b busy=%b need 1,0,1", active_bank, swap_done, busy);
        end
        tick();
        samp_strobe = 1'b1; tick(); samp_strobe = 1'b0;
        tests++;
        if (active_bank !== 1'b0 || swap_done !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL next_strobe_swaps: act=%b sw=%b ov=%b need 0,1,0", active_bank, swap_done, out_valid);
        end
        strobes(325);
    endtask

    task automatic test_reset_flush();
        int bad;
        do_load(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, bad);
        strobes(1);
        strobes(125);
        tests++;
        if (active_bank !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL flush_at_200: act=%b ov=%b busy=%b need 1,0,1", active_bank, out_valid, busy);
        end
        apply_reset();
        tests++;
        if (active_bank !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || wr_bank !== 1'b1 ||
            cfg_ready !== 1'b1 || wr_en !== 1'b0 || wr_data !== 16'd0 || coeff_sum !== 16'd0) begin
            fails++; $display("FAIL reset_mid_flush: act=%b ov=%b busy=%b wb=%b rdy=%b en=%b d=%h sum=%h need 0,0,0,1,1,0,0,0",
                              active_bank, out_valid, busy, wr_bank, cfg_ready, wr_en, wr_data, coeff_sum);
        end
        strobes(400);
        tests++;
        if (out_valid !== 1'b0 || active_bank !== 1'b0) begin
            fails++; $display("FAIL idle_strobes: ov=%b act=%b need 0,0", out_valid, active_bank);
        end
    endtask

    task automatic test_checksum();
        int bad;
        do_load(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bad);
        tests++;
        if (bad != 0 || coeff_sum !== 16'd0) begin
            fails++; $display("FAIL sum_before_swap: bad=%0d sum=%h need 0,0000", bad, coeff_sum);
        end
        strobes(1);
        tests++;
        if (coeff_sum !== SUM_CONST || active_bank !== 1'b1) begin
            fails++; $display("FAIL checksum: sum=%h act=%b need %h,1", coeff_sum, active_bank, SUM_CONST);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_err_early();
        test_err_nolast();
        test_coincident_strobe();
        test_reset_flush();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
